// File: rtl/serial_tx_if.sv
// serial_tx_if: two-requester byte handshake plus serial line status bundle
interface serial_tx_if;
  logic       req0, req1, ack0, ack1, tx, busy, grant, done;
  logic [7:0] data0, data1;
  modport master (output req0, data0, req1, data1, input ack0, ack1, tx, busy, grant, done);
  modport slave (input req0, data0, req1, data1, output ack0, ack1, tx, busy, grant, done);
endinterface

// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: round-robin arbiter between two byte requesters feeding one 8N1 serial transmitter
module serial_tx_arbiter #(
  parameter int CLKS_PER_BIT = 4
) (
  input logic        clk,
  input logic        rst,
  serial_tx_if.slave bus
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t     state_q, state_d;
  logic [7:0] presc_q, presc_d, shreg_q, shreg_d;
  logic [2:0] bit_q, bit_d;
  logic       tx_q, tx_d, busy_q, busy_d, ack0_q, ack0_d, ack1_q, ack1_d;
  logic       grant_q, grant_d, last_q, last_d, done_q, done_d;
  logic       bit_end, win;
  assign bit_end = presc_q == 8'(CLKS_PER_BIT - 1);
  // on a tie the requester that did not own the last frame wins
  assign win = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
  always_comb begin
    state_d = state_q;
    presc_d = presc_q + 8'd1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    grant_d = grant_q;
    last_d  = last_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        presc_d = 8'd0;
        if (bus.req0 || bus.req1) begin
          state_d = START;
          shreg_d = win ? bus.data1 : bus.data0;
          grant_d = win;
          last_d  = win;
          ack0_d  = ~win;
          ack1_d  = win;
        end
      end
      START: if (bit_end) begin
        state_d = DATA;
        presc_d = 8'd0;
        bit_d   = 3'd0;
      end
      DATA: if (bit_end) begin
        presc_d = 8'd0;
        state_d = bit_q == 3'd7 ? STOP : DATA;
        bit_d   = bit_q == 3'd7 ? bit_q : bit_q + 3'd1;
      end
      STOP: if (bit_end) begin
        state_d = IDLE;
        presc_d = 8'd0;
        done_d  = 1'b1;
      end
    endcase
    busy_d = state_d != IDLE;
    // tx is derived from the next state so the line itself comes straight off a flop
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? shreg_q[bit_d] : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      presc_q <= 8'd0;
      bit_q   <= 3'd0;
      shreg_q <= 8'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end
  assign bus.tx    = tx_q;
  assign bus.busy  = busy_q;
  assign bus.ack0  = ack0_q;
  assign bus.ack1  = ack1_q;
  assign bus.grant = grant_q;
  assign bus.done  = done_q;
endmodule

// File: tb/tb_serial_tx_arbiter.sv
// tb_serial_tx_arbiter: vector table, corner sequences and randomized frames against a frame-level model
module tb_serial_tx_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  serial_tx_if b4();
  serial_tx_if b1();
  serial_tx_arbiter #(.CLKS_PER_BIT(4)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));
  serial_tx_arbiter #(.CLKS_PER_BIT(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
  typedef struct {
    logic       r0, r1;
    logic [7:0] d0, d1;
    logic       g;
  } vec_t;
  vec_t tbl[10];
  int   n_cmp = 0, n_bad = 0;
  logic last_m[2];
  task automatic chk1(string nm, logic act, logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic chkn(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic tx_o(int d);    return d == 1 ? b1.tx    : b4.tx;    endfunction
  function automatic logic busy_o(int d);  return d == 1 ? b1.busy  : b4.busy;  endfunction
  function automatic logic grant_o(int d); return d == 1 ? b1.grant : b4.grant; endfunction
  function automatic logic done_o(int d);  return d == 1 ? b1.done  : b4.done;  endfunction
  function automatic logic ack0_o(int d);  return d == 1 ? b1.ack0  : b4.ack0;  endfunction
  function automatic logic ack1_o(int d);  return d == 1 ? b1.ack1  : b4.ack1;  endfunction
  task automatic put(int d, logic i, logic r, logic [7:0] x);
    if (d == 1 && i) begin b1.req1 = r; b1.data1 = x; end
    else if (d == 1) begin b1.req0 = r; b1.data0 = x; end
    else if (i) begin b4.req1 = r; b4.data1 = x; end
    else begin b4.req0 = r; b4.data0 = x; end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      put(d, 1'b0, 1'b0, 8'h00);
      put(d, 1'b1, 1'b0, 8'h00);
    end
    step();
    step();
    for (int d = 0; d < 2; d++) begin
      chk1("rst_tx", tx_o(d), 1'b1);
      chk1("rst_busy", busy_o(d), 1'b0);
      chk1("rst_ack0", ack0_o(d), 1'b0);
      chk1("rst_ack1", ack1_o(d), 1'b0);
      chk1("rst_done", done_o(d), 1'b0);
      chk1("rst_grant", grant_o(d), 1'b0);
      last_m[d] = 1'b1;
    end
    rst = 1'b0;
  endtask
  // Waits for the ack, then checks every cycle of the expected 10-bit frame and the done cycle.
  task automatic check_frame(int d, logic who, logic [7:0] byt, logic keep, logic [7:0] nxt, int exp_wait);
    int         cpb = d == 1 ? 1 : 4;
    int         n = 0;
    logic [9:0] fr = {1'b1, byt, 1'b0};
    do begin
      step();
      n++;
    end while (!(ack0_o(d) || ack1_o(d)) && n < 200);
    if (!(ack0_o(d) || ack1_o(d))) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ack_timeout: no ack after %0d cycles, required one", n);
      return;
    end
    if (exp_wait > 0) chkn("ack_latency", n, exp_wait);
    chk1("ack0", ack0_o(d), ~who);
    chk1("ack1", ack1_o(d), who);
    put(d, who, keep, nxt);
    for (int k = 0; k < 10 * cpb; k++) begin
      if (k > 0) begin
        step();
        chk1("ack_extra", ack0_o(d) | ack1_o(d), 1'b0);
      end
      chk1("tx_bit", tx_o(d), fr[k / cpb]);
      chk1("busy_frame", busy_o(d), 1'b1);
      chk1("grant", grant_o(d), who);
      chk1("done_early", done_o(d), 1'b0);
    end
    step();
    chk1("done_pulse", done_o(d), 1'b1);
    chk1("idle_tx", tx_o(d), 1'b1);
    chk1("idle_busy", busy_o(d), 1'b0);
    last_m[d] = who;
  endtask
  initial begin
    logic       r0, r1, who;
    logic [7:0] x0, x1;
    logic       g4[4];
    tbl[0] = '{1'b1, 1'b0, 8'hA5, 8'h00, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 8'h5A, 8'hC3, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 8'h33, 8'h44, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 8'h55, 8'h66, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 8'h77, 8'h88, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 8'h99, 8'hAA, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 8'h3C, 8'h00, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 8'h00, 8'hFF, 1'b1};
    tbl[8] = '{1'b1, 1'b0, 8'h80, 8'h01, 1'b0};
    tbl[9] = '{1'b1, 1'b1, 8'h01, 8'h80, 1'b1};
    g4 = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    put(0, 1'b0, 1'b1, 8'h11);
    put(0, 1'b1, 1'b1, 8'h22);
    check_frame(0, 1'b0, 8'h11, 1'b0, 8'h11, 1);
    check_frame(0, 1'b1, 8'h22, 1'b0, 8'h22, 1);
    // data of the winner is flipped right after ack; the latched byte must still go out
    for (int i = 0; i < 10; i++) begin
      put(0, 1'b0, tbl[i].r0, tbl[i].d0);
      put(0, 1'b1, tbl[i].r1, tbl[i].d1);
      x0 = tbl[i].g ? tbl[i].d1 : tbl[i].d0;
      check_frame(0, tbl[i].g, x0, 1'b0, ~x0, 1);
    end
    do_reset();
    put(0, 1'b0, 1'b1, 8'h12);
    put(0, 1'b1, 1'b1, 8'h34);
    for (int i = 0; i < 4; i++)
      check_frame(0, g4[i], g4[i] ? 8'h34 : 8'h12, 1'b1, g4[i] ? 8'h34 : 8'h12, 1);
    put(0, 1'b0, 1'b0, 8'h00);
    put(0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      chk1("held_stop_busy", busy_o(0), 1'b0);
    end
    do_reset();
    put(0, 1'b0, 1'b1, 8'h9E);
    step();
    chk1("abort_ack0", ack0_o(0), 1'b1);
    put(0, 1'b0, 1'b0, 8'h9E);
    for (int i = 0; i < 17; i++) step();
    chk1("abort_bit3", tx_o(0), 1'b1 ^ 1'b0);
    chk1("abort_busy_pre", busy_o(0), 1'b1);
    rst = 1'b1;
    put(0, 1'b1, 1'b1, 8'h5B);
    step();
    chk1("abort_tx", tx_o(0), 1'b1);
    chk1("abort_busy", busy_o(0), 1'b0);
    chk1("abort_done", done_o(0), 1'b0);
    step();
    chk1("abort_req_ignored", ack1_o(0), 1'b0);
    chk1("abort_busy2", busy_o(0), 1'b0);
    rst = 1'b0;
    last_m[0] = 1'b1;
    check_frame(0, 1'b1, 8'h5B, 1'b0, 8'h00, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk1("no_retx", busy_o(0), 1'b0);
    end
    put(1, 1'b0, 1'b1, 8'hFF);
    check_frame(1, 1'b0, 8'hFF, 1'b1, 8'h00, 1);
    check_frame(1, 1'b0, 8'h00, 1'b0, 8'h00, 1);
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        put(0, 1'b0, 1'b0, 8'h00);
        put(0, 1'b1, 1'b0, 8'h00);
        for (int j = 0; j < int'($urandom_range(1, 5)); j++) begin
          step();
          chk1("gap_tx", tx_o(0), 1'b1);
          chk1("gap_busy", busy_o(0), 1'b0);
        end
      end
      {r0, r1} = 2'($urandom_range(1, 3));
      x0 = 8'($urandom);
      x1 = 8'($urandom);
      put(0, 1'b0, r0, x0);
      put(0, 1'b1, r1, x1);
      who = (r0 && r1) ? ~last_m[0] : r1;
      check_frame(0, who, who ? x1 : x0, 1'($urandom_range(0, 1)), 8'($urandom), 1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
